// File: rtl/series_sum_fsm.sv
// Four-state Moore FSM that accumulates one series term per cycle (plain, shifted,
// squares, odd numbers) with a sticky saturating sum; all outputs are registered.
module series_sum_fsm #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  n,
    output logic [OUT_W-1:0] sum_out,
    output logic             done,
    output logic             busy,
    output logic             overflow,
    output logic [9:0]       led_out
);

    // Sum width also covers a single square term that may be wider than OUT_W.
    localparam int SW = (OUT_W + 1 > 2 * IN_W + 1) ? OUT_W + 1 : 2 * IN_W + 1;

    typedef enum logic [1:0] {IDLE, LOAD, ACC, DONE} state_t;

    state_t            state;
    logic [1:0]        mode_q;
    logic [IN_W-1:0]   n_q;
    logic [IN_W-1:0]   cnt;
    logic [IN_W-1:0]   idx;
    logic [OUT_W-1:0]  acc;
    logic              ovf;
    logic [2*IN_W-1:0] term;
    logic [2*IN_W-1:0] idx_w;
    logic [SW-1:0]     sum_next;
    logic              sat;

    always_comb begin
        idx_w = {{IN_W{1'b0}}, idx};
        case (mode_q)
            2'b10:   term = idx_w * idx_w;
            2'b11:   term = (idx_w << 1) - {{(2*IN_W-1){1'b0}}, 1'b1};
            default: term = idx_w;
        endcase
        sum_next = SW'(acc) + SW'(term);
        sat      = ovf || (sum_next > SW'({OUT_W{1'b1}}));
    end

    // Outputs decode the state held during the cycle, so they trail the state by one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mode_q   <= 2'b00;
            n_q      <= '0;
            cnt      <= '0;
            idx      <= '0;
            acc      <= '0;
            ovf      <= 1'b0;
            sum_out  <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            led_out  <= 10'h000;
        end else begin
            done <= (state == DONE);
            busy <= (state == LOAD) || (state == ACC);
            case (state)
                IDLE: led_out <= 10'h000;
                LOAD: begin
                    led_out  <= 10'h001;
                    sum_out  <= '0;
                    overflow <= 1'b0;
                end
                ACC:  led_out <= 10'h003;
                DONE: begin
                    led_out  <= {ovf, 6'b000000, 3'b111};
                    sum_out  <= acc;
                    overflow <= ovf;
                end
                default: led_out <= 10'h000;
            endcase

            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        n_q    <= n;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        acc   <= '0;
                        ovf   <= 1'b0;
                        idx   <= (mode_q == 2'b00) ? '0 : {{(IN_W-1){1'b0}}, 1'b1};
                        cnt   <= n_q;
                        state <= (n_q == '0) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        acc <= sat ? {OUT_W{1'b1}} : sum_next[OUT_W-1:0];
                        ovf <= sat;
                        idx <= idx + 1'b1;
                        cnt <= cnt - 1'b1;
                        if (cnt == {{(IN_W-1){1'b0}}, 1'b1})
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (!start)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_series_sum_fsm.sv
// Scoreboard bench: driver pushes model results, a negedge monitor checks each done pulse.
module tb_series_sum_fsm;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [1:0] mode;
    logic [3:0] n;
    logic [9:0] sum_out;
    logic       done, busy, overflow;
    logic [9:0] led_out;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic done_q = 1'b0;

    typedef struct {
        int sum;
        int ovf;
        int n;
        int acc_cyc;
    } exp_t;
    exp_t q[$];

    series_sum_fsm #(.IN_W(4), .OUT_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .n(n),
        .sum_out(sum_out), .done(done), .busy(busy), .overflow(overflow), .led_out(led_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: add the series terms with plain integers, clamp once anything exceeded 1023.
    function automatic void model(input int m, input int nn, output int s, output int o);
        s = 0;
        o = 0;
        for (int i = 0; i < nn; i++) begin
            int k;
            int t;
            k = (m == 0) ? i : i + 1;
            t = (m == 2) ? k * k : (m == 3) ? 2 * k - 1 : k;
            s += t;
            if (s > 1023) o = 1;
        end
        if (o != 0) s = 1023;
    endfunction

    always @(negedge clk) begin
        if (done && !done_q) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sum_out", int'(sum_out), e.sum);
                chk("overflow", int'(overflow), e.ovf);
                chk("led_out", int'(led_out), (e.ovf != 0) ? 32'h207 : 32'h007);
                chk("latency", cyc - e.acc_cyc, e.n + 2);
            end
        end
        done_q <= done;
    end

    task automatic run_txn(input int m, input int nn, input bit hold);
        exp_t e;
        int   bc;
        bit   got;
        model(m, nn, e.sum, e.ovf);
        e.n       = nn;
        e.acc_cyc = cyc + 1;
        q.push_back(e);
        mode  = 2'(m);
        n     = 4'(nn);
        start = 1'b1;
        bc    = 0;
        got   = 1'b0;
        for (int c = 0; c < 80 && !got; c++) begin
            @(negedge clk);
            mode = 2'($urandom);
            n    = 4'($urandom);
            if (busy) bc++;
            if (done) got = 1'b1;
        end
        if (!got) chk("done_timeout", 0, 1);
        chk("busy_cycles", bc, nn + 1);
        if (hold) begin
            repeat (3) begin
                @(negedge clk);
                chk("done_held", int'(done), 1);
            end
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("done_drop", int'(done), 0);
        chk("sum_held", int'(sum_out), e.sum);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00; n = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_sum", int'(sum_out), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_led", int'(led_out), 0);
        rst = 1'b0;
        @(negedge clk);

        run_txn(0, 5, 1'b1);
        run_txn(1, 15, 1'b0);
        run_txn(3, 15, 1'b0);
        run_txn(2, 15, 1'b1);
        run_txn(2, 0, 1'b0);

        // Abort on the third ACC cycle; start is ignored afterwards so nothing restarts.
        mode = 2'b01; n = 4'd10; start = 1'b1;
        repeat (4) @(negedge clk);
        abort = 1'b1; start = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_sum", int'(sum_out), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_ovf", int'(overflow), 0);
        run_txn(1, 4, 1'b0);

        // Reset mid-accumulation.
        mode = 2'b10; n = 4'd15; start = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("midrst_sum", int'(sum_out), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ovf", int'(overflow), 0);
        chk("midrst_led", int'(led_out), 0);
        rst = 1'b0;
        @(negedge clk);
        run_txn(0, 5, 1'b0);

        for (int t = 0; t < 30; t++)
            run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 1'($urandom));

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
